// File: rtl/audio_receiver_s_axis.sv
//------------------------------------------------------------------------------
// audio_receiver_s_axis
//   AXI4-Stream sink that collects Left/Right audio word pairs (TLAST marks the
//   Right word) and replays them MSB-first as I2S serial data, driven by the
//   codec's bclk/lrclk, which are asynchronous to the stream clock.
//
// Ports
//   S_AXIS_ACLK     in   sole clock
//   S_AXIS_ARESETN  in   asynchronous active-low reset
//   S_AXIS_TDATA    in   audio word, MSB-aligned (top AUDIO_BITS used)
//   S_AXIS_TSTRB    in   ignored
//   S_AXIS_TLAST    in   marks the Right word of a pair
//   S_AXIS_TVALID   in   upstream word valid
//   S_AXIS_TREADY   out  block accepts a word
//   bclk            in   codec bit clock (at most ACLK/4)
//   lrclk           in   codec word clock, 0 = Left, 1 = Right
//   sdata           out  I2S serial data to the DAC
//   frame_err       out  sticky TLAST framing error
//   underrun        out  sticky: no complete pair ready at Left frame start
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module audio_receiver_s_axis #(
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int AUDIO_BITS           = 24
) (
   input  logic                              S_AXIS_ACLK,
   input  logic                              S_AXIS_ARESETN,
   input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                              S_AXIS_TLAST,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic                              bclk,
   input  logic                              lrclk,
   output logic                              sdata,
   output logic                              frame_err,
   output logic                              underrun
);

   localparam int CW = $clog2(AUDIO_BITS + 1);

   typedef enum logic [1:0] {WAIT_L, WAIT_R, FULL} rx_state_e;

   rx_state_e              state_q, state_d;
   logic                   tready_q, tready_d;
   logic [AUDIO_BITS-1:0]  pair_l_q, pair_l_d;
   logic [AUDIO_BITS-1:0]  pair_r_q, pair_r_d;
   logic                   frame_err_q, frame_err_d;

   logic [1:0]             bclk_sync_q, lr_sync_q;
   logic                   bclk_prev_q;
   logic                   lr_prev_q, lr_prev_d;
   logic [AUDIO_BITS-1:0]  act_l_q, act_l_d;
   logic [AUDIO_BITS-1:0]  act_r_q, act_r_d;
   logic [AUDIO_BITS-1:0]  shift_q, shift_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic                   sdata_q, sdata_d;
   logic                   underrun_q, underrun_d;

   logic                   xfer;
   logic [AUDIO_BITS-1:0]  sample;
   logic                   bclk_fall;
   logic                   lr_s;
   logic                   lr_edge;
   logic                   handoff;

   // Only the top AUDIO_BITS of the word and no strobe bits are used.
   logic unused_inputs;
   if (AUDIO_BITS < C_S_AXIS_TDATA_WIDTH) begin : g_unused_lsbs
      assign unused_inputs = ^{S_AXIS_TSTRB, S_AXIS_TDATA[C_S_AXIS_TDATA_WIDTH-AUDIO_BITS-1:0]};
   end else begin : g_no_lsbs
      assign unused_inputs = ^S_AXIS_TSTRB;
   end

   assign xfer      = S_AXIS_TVALID & tready_q;
   assign sample    = S_AXIS_TDATA[C_S_AXIS_TDATA_WIDTH-1 -: AUDIO_BITS];
   assign bclk_fall = bclk_prev_q & ~bclk_sync_q[1];
   assign lr_s      = lr_sync_q[1];
   assign lr_edge   = bclk_fall & (lr_s != lr_prev_q);
   // Left frame start with a complete pair waiting: pair moves to the player.
   assign handoff   = lr_edge & ~lr_s & (state_q == FULL);

   //---------------------------------------------------------------- receive FSM
   always_comb begin
      state_d     = state_q;
      pair_l_d    = pair_l_q;
      pair_r_d    = pair_r_q;
      frame_err_d = frame_err_q;
      case (state_q)
         WAIT_L: if (xfer) begin
            if (S_AXIS_TLAST) begin
               frame_err_d = 1'b1;
            end else begin
               pair_l_d = sample;
               state_d  = WAIT_R;
            end
         end
         WAIT_R: if (xfer) begin
            if (S_AXIS_TLAST) begin
               pair_r_d = sample;
               state_d  = FULL;
            end else begin
               pair_l_d    = sample;
               frame_err_d = 1'b1;
            end
         end
         FULL:    if (handoff) state_d = WAIT_L;
         default: state_d = WAIT_L;
      endcase
      // Registered so TREADY stays low throughout reset.
      tready_d = (state_d != FULL);
   end

   //---------------------------------------------------------------- I2S player
   // The bit index AUDIO_BITS-1-bit_cnt is realised as a left-shifting copy of
   // the word, with sdata always taken from its MSB.
   always_comb begin
      lr_prev_d  = lr_prev_q;
      act_l_d    = act_l_q;
      act_r_d    = act_r_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      sdata_d    = sdata_q;
      underrun_d = underrun_q;
      if (bclk_fall) begin
         lr_prev_d = lr_s;
         if (lr_edge) begin
            if (!lr_s) begin
               if (state_q == FULL) begin
                  act_l_d = pair_l_q;
                  act_r_d = pair_r_q;
                  shift_d = pair_l_q;
               end else begin
                  underrun_d = 1'b1;
                  shift_d    = act_l_q;
               end
            end else begin
               shift_d = act_r_q;
            end
            sdata_d   = shift_d[AUDIO_BITS-1];
            shift_d   = shift_d << 1;
            bit_cnt_d = CW'(1);
         end else if (bit_cnt_q < CW'(AUDIO_BITS)) begin
            sdata_d   = shift_q[AUDIO_BITS-1];
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q + CW'(1);
         end else begin
            sdata_d = 1'b0;
         end
      end
   end

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state_q     <= WAIT_L;
         tready_q    <= 1'b0;
         pair_l_q    <= '0;
         pair_r_q    <= '0;
         frame_err_q <= 1'b0;
         bclk_sync_q <= '0;
         lr_sync_q   <= '0;
         bclk_prev_q <= 1'b0;
         lr_prev_q   <= 1'b1;
         act_l_q     <= '0;
         act_r_q     <= '0;
         shift_q     <= '0;
         bit_cnt_q   <= CW'(AUDIO_BITS);
         sdata_q     <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         tready_q    <= tready_d;
         pair_l_q    <= pair_l_d;
         pair_r_q    <= pair_r_d;
         frame_err_q <= frame_err_d;
         bclk_sync_q <= {bclk_sync_q[0], bclk};
         lr_sync_q   <= {lr_sync_q[0], lrclk};
         bclk_prev_q <= bclk_sync_q[1];
         lr_prev_q   <= lr_prev_d;
         act_l_q     <= act_l_d;
         act_r_q     <= act_r_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         sdata_q     <= sdata_d;
         underrun_q  <= underrun_d;
      end
   end

   assign S_AXIS_TREADY = tready_q;
   assign sdata         = sdata_q;
   assign frame_err     = frame_err_q;
   assign underrun      = underrun_q;

endmodule

// File: tb/tb_audio_receiver_s_axis.sv
`timescale 1ns/1ps
module tb_audio_receiver_s_axis;

   localparam int W  = 32;
   localparam int AB = 24;

   logic          aclk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  tdata;
   logic [W/8-1:0] tstrb;
   logic          tlast, tvalid, tready;
   logic          bclk, lrclk, sdata, frame_err, underrun;

   int n_cmp = 0;
   int n_err = 0;

   logic  exp_q[$];
   string name_q[$];

   audio_receiver_s_axis #(
      .C_S_AXIS_TDATA_WIDTH(W),
      .AUDIO_BITS(AB)
   ) dut (
      .S_AXIS_ACLK(aclk),
      .S_AXIS_ARESETN(rst_n),
      .S_AXIS_TDATA(tdata),
      .S_AXIS_TSTRB(tstrb),
      .S_AXIS_TLAST(tlast),
      .S_AXIS_TVALID(tvalid),
      .S_AXIS_TREADY(tready),
      .bclk(bclk),
      .lrclk(lrclk),
      .sdata(sdata),
      .frame_err(frame_err),
      .underrun(underrun)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: the DAC samples sdata on the rising bclk edge.
   always @(posedge bclk) begin
      logic  e;
      string nm;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         check(nm, {31'd0, sdata}, {31'd0, e});
      end
   end

   // One full I2S frame: 32 bclks Left then 32 bclks Right. lrclk changes on
   // the rising edge; the expected bit for each falling edge is queued.
   task automatic play_frame(input logic [AB-1:0] l, input logic [AB-1:0] r);
      logic [AB-1:0] w;
      for (int ch = 0; ch < 2; ch++) begin
         w = (ch == 1) ? r : l;
         for (int j = 0; j < 32; j++) begin
            bclk  = 1'b1;
            lrclk = (ch == 1);
            #80;
            bclk = 1'b0;
            exp_q.push_back((j < AB) ? w[AB-1-j] : 1'b0);
            name_q.push_back($sformatf("sdata %s w=%h slot%0d", (ch == 1) ? "R" : "L", w, j));
            #80;
         end
      end
   endtask

   task automatic send_word(input logic [W-1:0] d, input logic last);
      logic done;
      done = 1'b0;
      @(negedge aclk);
      tdata  = d;
      tlast  = last;
      tvalid = 1'b1;
      for (int k = 0; k < 3000; k++) begin
         if (tready) begin
            @(posedge aclk);
            done = 1'b1;
            break;
         end
         @(negedge aclk);
      end
      #1;
      tvalid = 1'b0;
      check($sformatf("handshake %h", d), {31'd0, done}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; tdata = '0; tstrb = '1; tlast = 1'b0; tvalid = 1'b0;
      bclk = 1'b0; lrclk = 1'b1;
      repeat (3) @(negedge aclk);
      check("reset tready", {31'd0, tready}, 32'd0);
      check("reset sdata", {31'd0, sdata}, 32'd0);
      check("reset frame_err", {31'd0, frame_err}, 32'd0);
      check("reset underrun", {31'd0, underrun}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge aclk);
      check("tready after reset", {31'd0, tready}, 32'd1);

      // Basic pair
      send_word(32'hABCDEF00, 1'b0);
      send_word(32'h12345600, 1'b1);
      @(negedge aclk);
      check("tready full", {31'd0, tready}, 32'd0);
      play_frame(24'hABCDEF, 24'h123456);
      check("underrun after pair1", {31'd0, underrun}, 32'd0);
      check("frame_err after pair1", {31'd0, frame_err}, 32'd0);
      check("tready after handoff", {31'd0, tready}, 32'd1);

      // Second pair offered while FULL
      send_word(32'h111111A5, 1'b0);
      send_word(32'h222222C3, 1'b1);
      @(negedge aclk);
      check("tready full pair2", {31'd0, tready}, 32'd0);
      fork
         begin
            send_word(32'h3C3C3C7E, 1'b0);
            send_word(32'hC3C3C311, 1'b1);
         end
         play_frame(24'h111111, 24'h222222);
      join
      play_frame(24'h3C3C3C, 24'hC3C3C3);
      check("underrun after pair3", {31'd0, underrun}, 32'd0);

      // Nothing waiting: repeat previous pair
      play_frame(24'h3C3C3C, 24'hC3C3C3);
      check("underrun set", {31'd0, underrun}, 32'd1);

      // Lone TLAST word in WAIT_L is dropped
      send_word(32'hDEADBEEF, 1'b1);
      @(negedge aclk);
      check("frame_err lone tlast", {31'd0, frame_err}, 32'd1);
      send_word(32'h5A5A5A00, 1'b0);
      send_word(32'hA5A5A5FF, 1'b1);
      play_frame(24'h5A5A5A, 24'hA5A5A5);

      // Reset in the middle of shifting a Left word
      send_word(32'hFFFFFF00, 1'b0);
      send_word(32'hFFFFFF00, 1'b1);
      for (int j = 0; j < 5; j++) begin
         bclk = 1'b1; lrclk = 1'b0; #80;
         bclk = 1'b0; #80;
      end
      check("sdata mid-shift", {31'd0, sdata}, 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("sdata in reset", {31'd0, sdata}, 32'd0);
      check("tready in reset", {31'd0, tready}, 32'd0);
      check("frame_err in reset", {31'd0, frame_err}, 32'd0);
      check("underrun in reset", {31'd0, underrun}, 32'd0);
      lrclk = 1'b1;
      repeat (5) @(negedge aclk);
      rst_n = 1'b1;
      repeat (3) @(negedge aclk);
      send_word(32'h13579B00, 1'b0);
      send_word(32'h2468AC00, 1'b1);
      play_frame(24'h13579B, 24'h2468AC);
      check("frame_err post-reset", {31'd0, frame_err}, 32'd0);
      check("underrun post-reset", {31'd0, underrun}, 32'd0);

      // Two non-TLAST words: the second becomes Left
      send_word(32'h0F0F0F00, 1'b0);
      send_word(32'h77777700, 1'b0);
      @(negedge aclk);
      check("frame_err double left", {31'd0, frame_err}, 32'd1);
      send_word(32'h88888800, 1'b1);
      play_frame(24'h777777, 24'h888888);

      // Final rising edge so the last queued slot is observed
      bclk = 1'b1; #80;
      bclk = 1'b0; #80;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/audio_receiver_s_axis.md
AUDIO_RECEIVER_S_AXIS -- requirements
Module: audio_receiver_s_axis

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, AXIS data width.
REQ-002 SHALL have parameter AUDIO_BITS, default 24, serialized bits per channel; AUDIO_BITS <= C_S_AXIS_TDATA_WIDTH.
REQ-003 SHALL have port S_AXIS_ACLK  in  1  sole clock.
REQ-004 SHALL have port S_AXIS_ARESETN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  audio word, MSB-aligned.
REQ-006 SHALL have port S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  ignored.
REQ-007 SHALL have port S_AXIS_TLAST  in  1  marks Right word of a pair.
REQ-008 SHALL have port S_AXIS_TVALID  in  1  upstream word valid.
REQ-009 SHALL have port S_AXIS_TREADY  out  1  block accepts word.
REQ-010 SHALL have port bclk  in  1  codec bit clock, asynchronous to S_AXIS_ACLK.
REQ-011 SHALL have port lrclk  in  1  codec word clock, 0 = Left, 1 = Right, asynchronous.
REQ-012 SHALL have port sdata  out  1  I2S serial data to DAC.
REQ-013 SHALL have port frame_err  out  1  sticky TLAST framing error.
REQ-014 SHALL have port underrun  out  1  sticky: no pair ready at frame start.

Function
REQ-015 SHALL complete a transfer on any ACLK edge with TVALID=1 and TREADY=1.
REQ-016 SHALL capture sample = TDATA[C_S_AXIS_TDATA_WIDTH-1 : C_S_AXIS_TDATA_WIDTH-AUDIO_BITS].
REQ-017 SHALL run a receive FSM with states WAIT_L, WAIT_R, FULL; TREADY=1 in WAIT_L and WAIT_R, 0 in FULL and in reset.
REQ-018 WAIT_L, transfer with TLAST=0: store in pair_L, go to WAIT_R.
REQ-019 WAIT_L, transfer with TLAST=1: discard word, set frame_err, stay in WAIT_L.
REQ-020 WAIT_R, transfer with TLAST=1: store in pair_R, go to FULL.
REQ-021 WAIT_R, transfer with TLAST=0: overwrite pair_L with the word, set frame_err, stay in WAIT_R.
REQ-022 FULL: hold until handoff (REQ-026), then go to WAIT_L; TREADY=1 on the cycle after handoff.
REQ-023 SHALL synchronize bclk and lrclk through two flops each; bclk_fall strobe = one-ACLK pulse on falling edge of synced bclk; bclk frequency SHALL be <= ACLK/4.
REQ-024 SHALL sample synced lrclk only on bclk_fall strobes into lr_prev.
REQ-025 On a strobe where synced lrclk != lr_prev: load shift word (act_L if lrclk=0, act_R if 1), sdata <= its MSB, bit_cnt <= 1.
REQ-026 On a strobe where lrclk goes 1->0 (Left frame start): if FULL, act_L <= pair_L and act_R <= pair_R before the load of REQ-025, so the new Left is shifted in the same strobe; if not FULL, keep act_L/act_R (repeat last pair) and set underrun.
REQ-027 On other strobes: if bit_cnt < AUDIO_BITS, sdata <= word bit [AUDIO_BITS-1-bit_cnt], bit_cnt++; else sdata <= 0.
REQ-028 sdata SHALL change only on bclk_fall strobes.
REQ-029 Simultaneous transfer and handoff cannot occur (TREADY=0 in FULL); handoff in WAIT_L/WAIT_R is an underrun and SHALL NOT disturb pair_L or the FSM state.
REQ-030 frame_err and underrun SHALL clear only on reset.

Reset
REQ-031 SHALL, while S_AXIS_ARESETN=0, force FSM=WAIT_L, TREADY=0, sdata=0, frame_err=0, underrun=0, pair_L/pair_R/act_L/act_R=0, bit_cnt=AUDIO_BITS, lr_prev=1, and both synchronizer chains=0.
REQ-032 Reset assertion mid-pair or mid-shift SHALL abort immediately; after release, first accepted word is treated as Left.

Verification
REQ-033 Pair L=0xABCDEF00, R=0x12345600 (TLAST on R), then lrclk 1->0 -> sdata emits 0xABCDEF MSB-first on next 24 strobes, 0 for the remaining Left bclks, then 0x123456 after lrclk 0->1.
REQ-034 Single word with TLAST=1 in WAIT_L -> frame_err=1, word dropped, next clean pair plays correctly.
REQ-035 Two TLAST=0 words then TLAST=1 -> frame_err=1, second word is the Left played, third word the Right.
REQ-036 Second pair offered while FULL -> TREADY=0 until Left frame start, pair accepted after handoff, no data lost.
REQ-037 No pair ready at Left frame start -> underrun=1, previous pair repeated bit-exact.
REQ-038 Reset asserted mid-shift -> sdata=0 and TREADY=0 within the reset, first post-reset word stored as Left.
